// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/ack port between the fetch sequencer (master) and memory (slave).
interface if_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_ack_i;
  logic [DATA_W-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, issues one outstanding imem request at a time,
// and presents words to ID through an output register backed by a single skid entry.
module if_fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               branch_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  if_fetch_ctrl_if.master    imem,
  output logic               if_valid_o,
  output logic [ADDR_W-1:0]  if_pc_o,
  output logic [DATA_W-1:0]  if_instr_o,
  output logic [15:0]        bubble_cnt_o
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_HOLD
  } state_e;

  state_e             state_q,      state_d;
  logic [ADDR_W-1:0]  fetch_pc_q,   fetch_pc_d;
  logic [ADDR_W-1:0]  req_addr_q,   req_addr_d;
  logic               req_q,        req_d;
  logic               drop_q,       drop_d;
  logic               out_valid_q,  out_valid_d;
  logic [ADDR_W-1:0]  out_pc_q,     out_pc_d;
  logic [DATA_W-1:0]  out_instr_q,  out_instr_d;
  logic               skid_valid_q, skid_valid_d;
  logic [ADDR_W-1:0]  skid_pc_q,    skid_pc_d;
  logic [DATA_W-1:0]  skid_instr_q, skid_instr_d;
  logic [CNT_W-1:0]   bubble_q,     bubble_d;

  logic [ADDR_W-1:0]  target_c;
  logic [ADDR_W-1:0]  pc_inc_c;
  logic               ack_c;
  logic               out_free_c;

  assign target_c   = branch_target_i & ~ADDR_W'(3);
  assign pc_inc_c   = fetch_pc_q + ADDR_W'(4);
  assign ack_c      = req_q & imem.imem_ack_i;
  assign out_free_c = !out_valid_q || !stall_i;

  // Next-state and next-output logic; redirect overrides everything at the end.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_addr_d   = req_addr_q;
    req_d        = req_q;
    drop_d       = drop_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    bubble_d     = (!out_valid_q && (bubble_q != '1)) ? bubble_q + CNT_W'(1) : bubble_q;

    if (!stall_i) out_valid_d = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        state_d    = S_FETCH;
        req_d      = 1'b1;
        fetch_pc_d = branch_i ? target_c : fetch_pc_q;
        req_addr_d = branch_i ? target_c : fetch_pc_q;
      end
      S_FETCH: begin
        if (ack_c) begin
          if (drop_q || branch_i) begin
            drop_d     = 1'b0;
            fetch_pc_d = branch_i ? target_c : fetch_pc_q;
            req_addr_d = branch_i ? target_c : fetch_pc_q;
          end else if (out_free_c) begin
            out_valid_d = 1'b1;
            out_pc_d    = req_addr_q;
            out_instr_d = imem.imem_rdata_i;
            fetch_pc_d  = pc_inc_c;
            req_addr_d  = pc_inc_c;
          end else begin
            skid_valid_d = 1'b1;
            skid_pc_d    = req_addr_q;
            skid_instr_d = imem.imem_rdata_i;
            fetch_pc_d   = pc_inc_c;
            req_addr_d   = pc_inc_c;
            req_d        = 1'b0;
            state_d      = S_HOLD;
          end
        end else if (branch_i) begin
          // request stays on the bus; its data is discarded when it finally acks
          drop_d     = 1'b1;
          fetch_pc_d = target_c;
        end
      end
      S_HOLD: begin
        if (branch_i) begin
          state_d    = S_FETCH;
          req_d      = 1'b1;
          fetch_pc_d = target_c;
          req_addr_d = target_c;
        end else if (!stall_i) begin
          out_valid_d  = skid_valid_q;
          out_pc_d     = skid_pc_q;
          out_instr_d  = skid_instr_q;
          skid_valid_d = 1'b0;
          state_d      = S_FETCH;
          req_d        = 1'b1;
          req_addr_d   = fetch_pc_q;
        end
      end
      default: begin
        state_d = S_BOOT;
        req_d   = 1'b0;
      end
    endcase

    if (branch_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      fetch_pc_q   <= RESET_PC;
      req_addr_q   <= RESET_PC;
      req_q        <= 1'b0;
      drop_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_instr_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      bubble_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_addr_q   <= req_addr_d;
      req_q        <= req_d;
      drop_q       <= drop_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      bubble_q     <= bubble_d;
    end
  end

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = req_addr_q;
  assign if_valid_o       = out_valid_q;
  assign if_pc_o          = out_pc_q;
  assign if_instr_o       = out_instr_q;
  assign bubble_cnt_o     = bubble_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: a scoreboard of expected presented words plus
// point checks on the request port; a second instance covers PC wrap-around.
module tb_if_fetch_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } word_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic [31:0] target;
  logic        mem_en;
  logic        dv;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [15:0] bubble;

  logic        zero;
  logic [31:0] zero_addr;
  logic        dv2;
  logic [31:0] if_pc2;
  logic [31:0] if_instr2;
  logic [15:0] bubble2;

  int          tests;
  int          fails;
  word_t       sb[$];
  logic [31:0] exp_pc;
  logic        drop_m;

  if_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) m  ();
  if_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) m2 ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign m.imem_ack_i    = m.imem_req_o & mem_en;
  assign m.imem_rdata_i  = mem_word(m.imem_addr_o);
  assign m2.imem_ack_i   = m2.imem_req_o;
  assign m2.imem_rdata_i = mem_word(m2.imem_addr_o);

  if_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall),
    .branch_i        (branch),
    .branch_target_i (target),
    .imem            (m),
    .if_valid_o      (dv),
    .if_pc_o         (if_pc),
    .if_instr_o      (if_instr),
    .bubble_cnt_o    (bubble)
  );

  if_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (zero),
    .branch_i        (zero),
    .branch_target_i (zero_addr),
    .imem            (m2),
    .if_valid_o      (dv2),
    .if_pc_o         (if_pc2),
    .if_instr_o      (if_instr2),
    .bubble_cnt_o    (bubble2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score the word ID takes at this edge, record the word memory returns, advance.
  task automatic step();
    word_t w;
    if (!branch && dv && !stall) begin
      if (sb.size() == 0) begin
        chk("extra_word", 64'(dv), 64'(0));
      end else begin
        w = sb.pop_front();
        chk("word_pc", 64'(if_pc), 64'(w.pc));
        chk("word_instr", 64'(if_instr), 64'(w.instr));
      end
    end
    if (m.imem_req_o && mem_en) begin
      if (!branch && !drop_m) begin
        chk("req_addr", 64'(m.imem_addr_o), 64'(exp_pc));
        sb.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
      drop_m = 1'b0;
    end else if (m.imem_req_o && branch) begin
      drop_m = 1'b1;
    end
    if (branch) begin
      sb.delete();
      exp_pc = target & ~32'h3;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0;
    exp_pc = 32'h0; drop_m = 1'b0;
    zero = 1'b0; zero_addr = 32'h0;
    rst_n = 1'b0; stall = 1'b0; branch = 1'b0; target = 32'h0; mem_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 64'(m.imem_req_o), 64'(0));
    chk("rst_addr", 64'(m.imem_addr_o), 64'(0));
    chk("rst_valid", 64'(dv), 64'(0));
    chk("rst_wrap_addr", 64'(m2.imem_addr_o), 64'(32'hFFFF_FFF8));

    // Boot, then the wrap instance streams while the main one waits for an ack
    rst_n = 1'b1;
    #1;
    chk("boot_req", 64'(m.imem_req_o), 64'(0));
    step();
    chk("fetch_req", 64'(m.imem_req_o), 64'(1));
    chk("fetch_addr", 64'(m.imem_addr_o), 64'(0));
    chk("wrap_req_addr", 64'(m2.imem_addr_o), 64'(32'hFFFF_FFF8));
    step();
    chk("wrap_valid", 64'(dv2), 64'(1));
    chk("wrap_pc0", 64'(if_pc2), 64'(32'hFFFF_FFF8));
    chk("wrap_instr0", 64'(if_instr2), 64'(mem_word(32'hFFFF_FFF8)));
    step();
    chk("wrap_pc1", 64'(if_pc2), 64'(32'hFFFF_FFFC));
    step();
    chk("wrap_pc2", 64'(if_pc2), 64'(32'h0));
    chk("wrap_instr2", 64'(if_instr2), 64'(mem_word(32'h0)));
    chk("wrap_bubble", 64'(bubble2), 64'(2));
    chk("bubble_pre", 64'(bubble), 64'(4));
    chk("req_waiting", 64'(m.imem_req_o), 64'(1));

    // Asynchronous reset in the middle of an outstanding request
    rst_n = 1'b0;
    #1;
    chk("arst_req", 64'(m.imem_req_o), 64'(0));
    chk("arst_valid", 64'(dv), 64'(0));
    chk("arst_bubble", 64'(bubble), 64'(0));
    chk("arst_wrap_valid", 64'(dv2), 64'(0));
    #2;
    rst_n = 1'b1;
    #1;
    chk("reboot_req", 64'(m.imem_req_o), 64'(0));
    step();
    chk("refetch_addr", 64'(m.imem_addr_o), 64'(0));

    // Streaming 0,4,8 with a zero-wait memory
    mem_en = 1'b1;
    step();
    chk("stream_valid0", 64'(dv), 64'(1));
    chk("stream_pc0", 64'(if_pc), 64'(0));
    step();
    chk("stream_pc4", 64'(if_pc), 64'(4));
    step();
    chk("stream_pc8", 64'(if_pc), 64'(8));

    // Back-pressure: 0x8 held, 0xC parked in skid, request dropped
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 64'(dv), 64'(1));
      chk("hold_pc", 64'(if_pc), 64'(8));
      chk("hold_req", 64'(m.imem_req_o), 64'(0));
    end
    stall = 1'b0;
    step();
    chk("skid_pc", 64'(if_pc), 64'(32'hC));
    chk("resume_req", 64'(m.imem_req_o), 64'(1));
    chk("resume_addr", 64'(m.imem_addr_o), 64'(32'h10));
    repeat (4) step();
    chk("pre_t4_addr", 64'(m.imem_addr_o), 64'(32'h20));

    // Redirect while the request to 0x20 waits three cycles
    mem_en = 1'b0;
    step();
    branch = 1'b1; target = 32'h100;
    step();
    branch = 1'b0;
    chk("t4_req_held", 64'(m.imem_req_o), 64'(1));
    chk("t4_addr_held", 64'(m.imem_addr_o), 64'(32'h20));
    chk("t4_valid", 64'(dv), 64'(0));
    step();
    mem_en = 1'b1;
    step();
    chk("t4_no_wrong_path", 64'(dv), 64'(0));
    chk("t4_new_addr", 64'(m.imem_addr_o), 64'(32'h100));
    step();
    chk("t4_pc", 64'(if_pc), 64'(32'h100));
    chk("t4_pc_valid", 64'(dv), 64'(1));
    step();

    // Redirect and ack on the same cycle while ID is stalled
    stall = 1'b1; branch = 1'b1; target = 32'h203;
    step();
    branch = 1'b0; stall = 1'b0;
    chk("t5_valid", 64'(dv), 64'(0));
    chk("t5_req", 64'(m.imem_req_o), 64'(1));
    chk("t5_addr", 64'(m.imem_addr_o), 64'(32'h200));
    repeat (3) step();

    // Redirect while parked in HOLD flushes output and skid
    stall = 1'b1;
    step();
    chk("t7_hold_req", 64'(m.imem_req_o), 64'(0));
    step();
    branch = 1'b1; target = 32'h400;
    step();
    branch = 1'b0; stall = 1'b0;
    chk("t7_valid", 64'(dv), 64'(0));
    chk("t7_req", 64'(m.imem_req_o), 64'(1));
    chk("t7_addr", 64'(m.imem_addr_o), 64'(32'h400));
    repeat (2) step();

    // Drain and confirm nothing was lost
    mem_en = 1'b0;
    repeat (2) step();
    chk("drained", 64'(sb.size()), 64'(0));
    chk("drain_valid", 64'(dv), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
